// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - length-prefixed program loader that screens opcodes before writing instruction memory.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CKSUM_EN.
module instr_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_WORD,
    S_CHECK,
    S_WRITE,
`ifdef LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef LOADER_CKSUM_EN
  localparam state_t S_TAIL = S_CKSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  localparam logic [16:0]       CAP     = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0]   WC_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADR_ONE = 1;

  state_t      state, state_nxt;
  logic [1:0]  err_nxt;
  logic [15:0] len;
  logic [15:0] len_n;
  logic [1:0]  byte_idx;
  logic        accept;
  logic        more_words;
`ifdef LOADER_CKSUM_EN
  logic [7:0]  cksum;
`endif

  function automatic logic legal_op(input logic [6:0] op);
    case (op)
      7'd0, 7'd1, 7'd2, 7'd16, 7'd17, 7'd18, 7'd19, 7'd48, 7'd49: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  endfunction

  assign accept     = in_valid && in_ready;
  assign len_n      = {len[15:8], in_data};
  // word_count still holds the pre-increment value while in WRITE
  assign more_words = ({1'b0, len} > (17'(word_count) + 17'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 2'd0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_n} > CAP) begin
            state_nxt = S_ERR;
            err_nxt   = 2'd1;
          end else if (len_n == 16'd0) begin
            state_nxt = S_TAIL;
          end else begin
            state_nxt = S_WORD;
          end
        end
      end
      S_WORD: begin
        if (accept && byte_idx == 2'd3) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (legal_op(im_wdata[31:25])) begin
          state_nxt = S_WRITE;
        end else begin
          state_nxt = S_ERR;
          err_nxt   = 2'd2;
        end
      end
      S_WRITE: begin
        state_nxt = more_words ? S_WORD : S_TAIL;
      end
`ifdef LOADER_CKSUM_EN
      S_CKSUM: begin
        if (accept) begin
          if (in_data == cksum) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ERR;
            err_nxt   = 2'd3;
          end
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    im_we    = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_WORD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef LOADER_CKSUM_EN
      S_CKSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_CHECK: busy = 1'b1;
      S_WRITE: begin
        busy  = 1'b1;
        im_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len        <= 16'd0;
      byte_idx   <= 2'd0;
      im_addr    <= '0;
      im_wdata   <= 32'd0;
      word_count <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      cpu_hold   <= 1'b1;
`ifdef LOADER_CKSUM_EN
      cksum      <= 8'd0;
`endif
    end else begin
      // start is only honoured outside a load; busy filters it
      if (start && !busy) begin
        byte_idx   <= 2'd0;
        im_addr    <= '0;
        word_count <= '0;
        done       <= 1'b0;
        err        <= 1'b0;
        err_code   <= 2'd0;
        cpu_hold   <= 1'b1;
`ifdef LOADER_CKSUM_EN
        cksum      <= 8'd0;
`endif
      end
      if (accept) begin
        case (state)
          S_LEN_HI: len[15:8] <= in_data;
          S_LEN_LO: len[7:0]  <= in_data;
          S_WORD: begin
            im_wdata <= {im_wdata[23:0], in_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CKSUM_EN
            cksum    <= cksum ^ in_data;
`endif
          end
          default: ;
        endcase
      end
      if (state == S_WRITE) begin
        im_addr    <= im_addr + ADR_ONE;
        word_count <= word_count + WC_ONE;
      end
      if (state_nxt == S_DONE && state != S_DONE) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (state_nxt == S_ERR && state != S_ERR) begin
        err      <= 1'b1;
        err_code <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized bench for instr_loader against a stream-level reference model.
module tb_instr_loader;
  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   word_count;

  always #5 clk = ~clk;

  instr_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .word_count(word_count)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  stream[$];
  logic [39:0] got_w[$];
  logic [39:0] exp_w[$];
  logic        exp_done;
  logic        exp_err;
  logic [1:0]  exp_code;
  logic [6:0]  legal_tbl[9] = '{7'd0, 7'd1, 7'd2, 7'd16, 7'd17, 7'd18, 7'd19, 7'd48, 7'd49};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (im_we) got_w.push_back({im_addr, im_wdata});

  function automatic bit legal(input logic [6:0] op);
    return op inside {7'd0, 7'd1, 7'd2, 7'd16, 7'd17, 7'd18, 7'd19, 7'd48, 7'd49};
  endfunction

  // Builds a stream of n words; word bad_at gets an illegal opcode, bad_ck corrupts the trailer.
  task automatic gen(input int n, input int bad_at, input bit bad_ck);
    logic [7:0]  x;
    logic [31:0] w;
    logic [6:0]  op;
    x = 8'h00;
    stream.delete();
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
    if (n > CAP) return;
    for (int i = 0; i < n; i++) begin
      if (i == bad_at) begin
        do op = 7'($urandom_range(0, 127)); while (legal(op));
      end else begin
        op = legal_tbl[$urandom_range(0, 8)];
      end
      w = {op, 25'($urandom)};
      for (int b = 3; b >= 0; b--) begin
        stream.push_back(w[b*8 +: 8]);
        x ^= w[b*8 +: 8];
      end
    end
    stream.push_back(bad_ck ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  task automatic model();
    int          n;
    logic [31:0] w;
    logic [7:0]  x;
    exp_w.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_code = 2'd0;
    x = 8'h00;
    n = {stream[0], stream[1]};
    if (n > CAP) begin
      exp_err = 1'b1; exp_code = 2'd1; return;
    end
    for (int i = 0; i < n; i++) begin
      w = {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]};
      if (!legal(w[31:25])) begin
        exp_err = 1'b1; exp_code = 2'd2; return;
      end
      exp_w.push_back({8'(i), w});
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
`ifdef LOADER_CKSUM_EN
    if (stream[2+4*n] != x) begin
      exp_err = 1'b1; exp_code = 2'd3; return;
    end
`endif
    exp_done = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input int nbytes);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < nbytes && !(done || err) && cyc < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = stream[idx];
      acc = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_load(input string tag);
    int cyc = 0;
    while (!(done || err) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_end"}, done | err, 1'b1);
    model();
    check({tag, "_nwr"}, got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), got_w[i], exp_w[i]);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_code"}, err_code, exp_code);
    check({tag, "_wc"}, word_count, exp_w.size());
    check({tag, "_hold"}, cpu_hold, !exp_done);
    check({tag, "_idle"}, {busy, in_ready, im_we}, 3'b000);
  endtask

  task automatic run_load(input string tag);
    got_w.delete();
    pulse_start();
    check({tag, "_busy"}, {busy, cpu_hold, done, err}, 4'b1100);
    drive(stream.size());
    finish_load(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst", {in_ready, im_we, im_addr, im_wdata, busy, done, err, err_code, word_count, cpu_hold},
          {1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b0, 9'h0, 1'b1});
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel", {in_ready, busy, cpu_hold}, 3'b001);

    stream = '{8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h60, 8'h00, 8'h00, 8'h04, 8'h64};
    run_load("ex");
    check("ex_w0", got_w.size() > 0 ? got_w[0] : 40'h0, {8'h00, 32'h00112233});
    check("ex_w1", got_w.size() > 1 ? got_w[1] : 40'h0, {8'h01, 32'h60000004});
    check("ex_st", {done, cpu_hold, word_count}, {1'b1, 1'b0, 9'd2});

    stream = '{8'h00, 8'h01, 8'h06, 8'h00, 8'h00, 8'h00, 8'h06};
    run_load("ill");
    check("ill_st", {err, err_code, cpu_hold, 6'(got_w.size())}, {1'b1, 2'd2, 1'b1, 6'd0});

    stream = '{8'h01, 8'h01};
    run_load("ovf");
    check("ovf_st", {err, err_code, in_ready}, {1'b1, 2'd1, 1'b0});

`ifdef LOADER_CKSUM_EN
    stream = '{8'h00, 8'h01, 8'h22, 8'h00, 8'h00, 8'h05, 8'h00};
    run_load("ckbad");
    check("ckbad_st", {err, err_code, word_count}, {1'b1, 2'd3, 9'd1});
    stream = '{8'h00, 8'h01, 8'h22, 8'h00, 8'h00, 8'h05, 8'h27};
    run_load("ckok");
    check("ckok_st", {done, cpu_hold}, 2'b10);
`endif

    gen(0, -1, 1'b0);
    run_load("n0");
    gen(CAP, -1, 1'b0);
    run_load("nmax");
    gen(CAP + 1, -1, 1'b0);
    run_load("nover");

    gen(3, -1, 1'b0);
    got_w.delete();
    pulse_start();
    drive(4);
    in_valid = 1'b1;
    in_data  = stream[4];
    rst_n    = 1'b0;
    #1;
    check("midrst", {in_ready, im_we, im_addr, im_wdata, busy, done, err, err_code, word_count, cpu_hold},
          {1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b0, 9'h0, 1'b1});
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("midrst_nowr", got_w.size(), 0);
    run_load("after_rst");

    for (int t = 0; t < 40; t++) begin
      int kind;
      int n;
      kind = $urandom_range(0, 9);
      n    = $urandom_range(0, 8);
      if (kind == 0)
        gen(CAP + 1 + $urandom_range(0, 300), -1, 1'b0);
      else if (kind == 1 && n > 0)
        gen(n, $urandom_range(0, n - 1), 1'b0);
      else
        gen(n, -1, kind == 2);
      run_load($sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Sequential program loader that writes the instruction words the CPU's opcode decoder consumes. It accepts a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word's 7-bit opcode field is checked against the supported instruction set before the word is written into instruction memory. The CPU is held off (`cpu_hold`) until a complete, legal program has been loaded.

## Interface
- `ADDR_W`, 8, instruction-memory address width; capacity is 2^ADDR_W words.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle pulse that begins a load.
- `in_valid` input 1: `in_data` is valid.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `im_we` output 1: instruction-memory write strobe.
- `im_addr` output ADDR_W: word address of the write.
- `im_wdata` output 32: instruction word to write.
- `cpu_hold` output 1: keeps the CPU stalled or in reset while high.
- `busy` output 1: a load is in progress.
- `done` output 1: load completed successfully (sticky).
- `err` output 1: load aborted (sticky).
- `err_code` output 2: abort cause.
  - 1 = length overflow.
  - 2 = illegal opcode.
  - 3 = checksum mismatch.
- `word_count` output ADDR_W+1: number of words written in the current or last load.

## Operation
- Stream format:
  - LEN_HI, then LEN_LO: N, a 16-bit word count.
  - N words, 4 bytes each, MSB first.
  - Checksum byte, only with `LOADER_CKSUM_EN`.
- Opcode field: word[31:25], i.e. byte0[7:1].
- Legal opcodes: 0, 1, 2, 16, 17, 18, 19, 48, 49. Any other value is illegal.
- States:
  - IDLE → LEN_HI on `start`.
  - LEN_HI → LEN_LO on byte accept.
  - LEN_LO → WORD on byte accept.
  - WORD (byte index 0–3) → CHECK after the 4th byte.
  - CHECK → WRITE if the opcode is legal; → ERR(2) if illegal. An illegal word is not written.
  - WRITE → WORD if more words remain; otherwise → CKSUM (macro on) or DONE.
  - CKSUM → DONE on match; → ERR(3) on mismatch.
  - DONE and ERR → LEN_HI on `start`.
- Length checks, evaluated when LEN_LO is accepted:
  - N > 2^ADDR_W → ERR(1).
  - N = 0 → CKSUM (macro on) or DONE; no writes occur.
- WRITE state:
  - `im_we` = 1 for exactly one cycle.
  - `im_addr` = current address; `im_wdata` = assembled word.
  - Address and `word_count` increment on the following edge.
- Address counter: starts at 0 on each load. It cannot wrap because of the length check; N = 2^ADDR_W writes addresses 0 through 2^ADDR_W−1.
- `start` while `busy` is ignored. `start` in DONE or ERR clears `done`/`err`/`err_code`/`word_count`, resets the address to 0, and raises `cpu_hold`.
- `in_valid` while `in_ready` = 0 is ignored, and the byte is not consumed.

## Timing
- Reset values:
  - `in_ready`, `im_we`, `im_addr`, `im_wdata`, `busy`, `done`, `err`, `err_code`, `word_count` = 0.
  - `cpu_hold` = 1.
  - State = IDLE.
- `in_ready` = 1 only in LEN_HI, LEN_LO, WORD and CKSUM.
- A byte is taken on a rising edge when `in_valid` && `in_ready`.
- Per-word cost: 4 accept cycles + CHECK + WRITE. Minimum 6 cycles per word with `in_valid` held high.
- `busy` = 1 in every state except IDLE, DONE and ERR.
- `done` or `err` rises on the edge that enters DONE or ERR.
- `cpu_hold`:
  - Falls on the edge that enters DONE.
  - Stays 1 in IDLE and ERR.
- Reset asserted mid-load: all outputs return to reset values immediately, with no partial write strobe. Memory contents already written are left untouched.

## Configuration
- `LOADER_CKSUM_EN` defined:
  - After the last word (or after LEN_LO when N = 0), one more byte is accepted.
  - That byte must equal the XOR of all 4N word bytes; with N = 0 it must be 0x00.
  - Mismatch → ERR(3); `cpu_hold` stays 1.
- `LOADER_CKSUM_EN` undefined: the CKSUM state does not exist, and the final WRITE goes directly to DONE.

## Test plan
- Reset with `rst_n` = 0, then release → all outputs 0 except `cpu_hold` = 1; `in_ready` = 0.
- `start`, then bytes 00 02 / 00 11 22 33 / 60 00 00 04 (+ 64 with the macro) → two `im_we` pulses: addr 0 with 0x00112233 and addr 1 with 0x60000004. Then `done` = 1, `cpu_hold` = 0, `word_count` = 2.
- `start`, then 00 01 / 06 00 00 00 (opcode 3) → no `im_we`, `err` = 1, `err_code` = 2, `cpu_hold` = 1.
- ADDR_W = 8, `start`, then 01 01 (N = 257) → ERR with `err_code` = 1 right after LEN_LO; `in_ready` = 0.
- Macro on: valid one-word load of 22 00 00 05 with checksum byte 0x00 (correct value 0x27) → `err_code` = 3 and `word_count` = 1. Re-`start` with correct data → `done` = 1.
- Drop `rst_n` during the 3rd byte of word 1 → outputs return to reset values within the same cycle. A new load then starts at addr 0.
